exc_ctrl: RTL and testbench

Precise-exception controller at the memory/commit boundary of the pipeline, directly upstream of the CP0 register file. It collects per-instruction exception flags from the commit stage and arbitrates them by MIPS priority. It samples the CP0 interrupt-response line and drives one-cycle exception/ERET pulses into CP0. It then flushes the pipeline and holds a redirect request towards instruction fetch until fetch accepts it.

---
 rtl/exc_ctrl_pkg.sv | 41 ++++
 rtl/exc_prio.sv | 52 +++++
 rtl/exc_ctrl.sv | 117 +++++++++++
 tb/tb_exc_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, commit-flag bit positions and CP0 Status fields
// used by exc_ctrl, exc_prio and CP0.
package exc_ctrl_pkg;

  localparam logic [31:0] RESET_VEC    = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_BEV  = 32'hBFC0_0380;
  localparam logic [31:0] EXC_VEC_NORM = 32'h8000_0180;

  localparam logic [4:0] EXC_Int  = 5'h00;
  localparam logic [4:0] EXC_AdEL = 5'h04;
  localparam logic [4:0] EXC_AdES = 5'h05;
  localparam logic [4:0] EXC_Sys  = 5'h08;
  localparam logic [4:0] EXC_Bp   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_Ov   = 5'h0C;

  // cm_exc = {AdEL_fetch, RI, Ov, Sys, Bp, AdEL_data, AdES}
  localparam int CM_EXC_W     = 7;
  localparam int EXC_ADES_BIT = 0;
  localparam int EXC_ADELD_BIT = 1;
  localparam int EXC_BP_BIT   = 2;
  localparam int EXC_SYS_BIT  = 3;
  localparam int EXC_OV_BIT   = 4;
  localparam int EXC_RI_BIT   = 5;
  localparam int EXC_ADELF_BIT = 6;

  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_BEV_BIT = 22;

  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_PC   = 2'd1,
    BV_DATA = 2'd2
  } bv_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exc_prio.sv
// Combinational MIPS exception priority encoder: {int, cm_exc} -> excode.
// EXC_BREAK_EN: Bp gets its own code; otherwise Bp is folded into RI.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic                i_int,
  input  logic [CM_EXC_W-1:0] i_exc,
  output logic [4:0]          o_excode,
  output bv_sel_e             o_bv_sel,
  output logic                o_hit
);

  logic w_ri;
  logic w_bp;

`ifdef EXC_BREAK_EN
  assign w_ri = i_exc[EXC_RI_BIT];
  assign w_bp = i_exc[EXC_BP_BIT];
`else
  assign w_ri = i_exc[EXC_RI_BIT] | i_exc[EXC_BP_BIT];
  assign w_bp = 1'b0;
`endif

  always_comb begin
    o_excode = EXC_Int;
    o_bv_sel = BV_NONE;
    o_hit    = 1'b1;
    if (i_int) begin
      o_excode = EXC_Int;
    end else if (i_exc[EXC_ADELF_BIT]) begin
      o_excode = EXC_AdEL;
      o_bv_sel = BV_PC;
    end else if (w_ri) begin
      o_excode = EXC_RI;
    end else if (i_exc[EXC_OV_BIT]) begin
      o_excode = EXC_Ov;
    end else if (i_exc[EXC_SYS_BIT]) begin
      o_excode = EXC_Sys;
    end else if (w_bp) begin
      o_excode = EXC_Bp;
    end else if (i_exc[EXC_ADELD_BIT]) begin
      o_excode = EXC_AdEL;
      o_bv_sel = BV_DATA;
    end else if (i_exc[EXC_ADES_BIT]) begin
      o_excode = EXC_AdES;
      o_bv_sel = BV_DATA;
    end else begin
      o_hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Precise-exception controller at the commit boundary: pulses exceptions/ERET
// into CP0, flushes, and holds a fetch redirect until accepted. Macro: EXC_BREAK_EN.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cm_valid,
  output logic                cm_ready,
  input  logic [31:0]         cm_pc,
  input  logic                cm_bd,
  input  logic [CM_EXC_W-1:0] cm_exc,
  input  logic                cm_eret,
  input  logic [31:0]         cm_data_addr,
  input  logic                ext_int_response,
  input  logic [31:0]         cp0_status,
  input  logic [31:0]         cp0_epc,
  output logic                exc_valid,
  output logic [4:0]          exc_excode,
  output logic                exc_bd,
  output logic [31:0]         exc_epc,
  output logic [31:0]         exc_badvaddr,
  output logic                exc_eret,
  output logic                flush,
  output logic                redir_valid,
  input  logic                redir_ready,
  output logic [31:0]         redir_pc
);

  exc_state_e  r_state;
  exc_state_e  w_next;
  logic        r_int_pend;
  logic [31:0] r_redir_pc;

  logic        w_exl;
  logic        w_bev;
  logic        w_int;
  logic        w_idle;
  logic        w_event;
  logic        w_hit;
  logic [4:0]  w_code;
  bv_sel_e     w_bv_sel;
  logic [31:0] w_target;
  logic [31:0] w_victim_pc;
  logic        w_unused_status;

  assign w_exl  = cp0_status[STATUS_EXL_BIT];
  assign w_bev  = cp0_status[STATUS_BEV_BIT];
  assign w_int  = r_int_pend & ~w_exl;
  assign w_idle = (r_state == ST_IDLE);
  assign w_unused_status = ^{cp0_status[31:23], cp0_status[21:2], cp0_status[0]};

  exc_prio u_prio (
    .i_int    (w_int),
    .i_exc    (cm_exc),
    .o_excode (w_code),
    .o_bv_sel (w_bv_sel),
    .o_hit    (w_hit)
  );

  // ERET only counts when the encoder found nothing; Int always outranks it.
  assign w_event     = cm_valid & w_idle & (w_int | (|cm_exc) | cm_eret);
  assign w_target    = w_hit ? (w_bev ? EXC_VEC_BEV : EXC_VEC_NORM) : cp0_epc;
  assign w_victim_pc = cm_bd ? (cm_pc - 32'd4) : cm_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_int_pend <= 1'b0;
      r_redir_pc <= 32'd0;
    end else begin
      r_state    <= w_next;
      r_int_pend <= ext_int_response & ~w_exl;
      if (w_event) r_redir_pc <= w_target;
    end
  end

  always_comb begin
    w_next       = r_state;
    exc_valid    = 1'b0;
    exc_eret     = 1'b0;
    exc_excode   = 5'd0;
    exc_bd       = 1'b0;
    exc_epc      = 32'd0;
    exc_badvaddr = 32'd0;
    flush        = 1'b0;
    redir_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_event) begin
          w_next     = ST_REDIR;
          exc_valid  = 1'b1;
          exc_eret   = ~w_hit;
          exc_excode = w_hit ? w_code : 5'd0;
          exc_bd     = cm_bd;
          exc_epc    = w_victim_pc;
          flush      = 1'b1;
          case (w_bv_sel)
            BV_PC:   exc_badvaddr = cm_pc;
            BV_DATA: exc_badvaddr = cm_data_addr;
            default: exc_badvaddr = 32'd0;
          endcase
        end
      end
      ST_REDIR: begin
        flush       = 1'b1;
        redir_valid = 1'b1;
        if (redir_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign cm_ready = w_idle;
  assign redir_pc = r_redir_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: vector table plus scoreboard queues for
// CP0 pulses and fetch redirects, and hand-written stall/reset sequences.
module tb_exc_ctrl;

  logic        clk;
  logic        reset;
  logic        cm_valid;
  logic        cm_ready;
  logic [31:0] cm_pc;
  logic        cm_bd;
  logic [6:0]  cm_exc;
  logic        cm_eret;
  logic [31:0] cm_data_addr;
  logic        ext_int_response;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;

  exc_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .cm_valid         (cm_valid),
    .cm_ready         (cm_ready),
    .cm_pc            (cm_pc),
    .cm_bd            (cm_bd),
    .cm_exc           (cm_exc),
    .cm_eret          (cm_eret),
    .cm_data_addr     (cm_data_addr),
    .ext_int_response (ext_int_response),
    .cp0_status       (cp0_status),
    .cp0_epc          (cp0_epc),
    .exc_valid        (exc_valid),
    .exc_excode       (exc_excode),
    .exc_bd           (exc_bd),
    .exc_epc          (exc_epc),
    .exc_badvaddr     (exc_badvaddr),
    .exc_eret         (exc_eret),
    .flush            (flush),
    .redir_valid      (redir_valid),
    .redir_ready      (redir_ready),
    .redir_pc         (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef EXC_BREAK_EN
  localparam logic [4:0] BP_CODE    = 5'h09;
  localparam logic [4:0] SYSBP_CODE = 5'h08;
`else
  localparam logic [4:0] BP_CODE    = 5'h0A;
  localparam logic [4:0] SYSBP_CODE = 5'h0A;
`endif

  typedef struct {
    logic        irq, exl, bev;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  exc;
    logic        eret;
    logic [31:0] addr, epc_in;
    logic        ev;
    logic [4:0]  code;
    logic        e_eret, chk_bv;
    logic [31:0] e_epc, e_badv, e_redir;
  } vec_t;

  typedef struct {
    logic [4:0]  code;
    logic        bd, eret, chk_bv;
    logic [31:0] epc, badv;
  } exp_t;

  exp_t        qe[$];
  logic [31:0] rq[$];
  exp_t        mon_e;
  vec_t        vecs[16];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          started  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(logic irq, logic exl, logic bev, logic [31:0] pc, logic bd,
                              logic [6:0] exc, logic eret, logic [31:0] addr, logic [31:0] epc_in,
                              logic ev, logic [4:0] code, logic e_eret, logic chk_bv,
                              logic [31:0] e_epc, logic [31:0] e_badv, logic [31:0] e_redir);
    vec_t v;
    v.irq = irq; v.exl = exl; v.bev = bev; v.pc = pc; v.bd = bd; v.exc = exc;
    v.eret = eret; v.addr = addr; v.epc_in = epc_in; v.ev = ev; v.code = code;
    v.e_eret = e_eret; v.chk_bv = chk_bv; v.e_epc = e_epc; v.e_badv = e_badv;
    v.e_redir = e_redir;
    return v;
  endfunction

  // Scoreboard monitor: every CP0 pulse and every redirect cycle must match the queues.
  always @(negedge clk) begin
    if (started && !reset) begin
      if (exc_valid) begin
        if (qe.size() == 0) chk("unexpected_exc_valid", 32'd1, 32'd0);
        else begin
          mon_e = qe.pop_front();
          chk("exc_eret", {31'd0, exc_eret}, {31'd0, mon_e.eret});
          chk("exc_bd", {31'd0, exc_bd}, {31'd0, mon_e.bd});
          chk("flush_evt", {31'd0, flush}, 32'd1);
          if (!mon_e.eret) begin
            chk("exc_excode", {27'd0, exc_excode}, {27'd0, mon_e.code});
            chk("exc_epc", exc_epc, mon_e.epc);
          end
          if (mon_e.chk_bv) chk("exc_badvaddr", exc_badvaddr, mon_e.badv);
        end
      end
      if (redir_valid) begin
        if (rq.size() == 0) chk("unexpected_redir", 32'd1, 32'd0);
        else begin
          chk("redir_pc", redir_pc, rq[0]);
          chk("flush_redir", {31'd0, flush}, 32'd1);
          if (redir_ready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    cm_valid = 0; cm_pc = 0; cm_bd = 0; cm_exc = 0; cm_eret = 0; cm_data_addr = 0;
    ext_int_response = 0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cm_ready && !redir_valid) begin ok = 1; break; end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    logic [31:0] st;
    @(posedge clk); #1;
    st = '0; st[22] = v.bev; st[1] = v.exl;
    cp0_status = st; cp0_epc = v.epc_in; redir_ready = 1;
    ext_int_response = v.irq;
    if (v.irq) begin @(posedge clk); #1; end
    cm_valid = 1; cm_pc = v.pc; cm_bd = v.bd; cm_exc = v.exc; cm_eret = v.eret;
    cm_data_addr = v.addr;
    if (v.ev) begin
      e.code = v.code; e.bd = v.bd; e.eret = v.e_eret; e.chk_bv = v.chk_bv;
      e.epc = v.e_epc; e.badv = v.e_badv;
      qe.push_back(e);
      rq.push_back(v.e_redir);
    end
    @(negedge clk);
    chk("event", {31'd0, exc_valid}, {31'd0, v.ev});
    @(posedge clk); #1;
    idle_inputs();
    if (v.ev) begin
      @(negedge clk);
      chk("redir_valid_n1", {31'd0, redir_valid}, 32'd1);
      chk("cm_ready_redir", {31'd0, cm_ready}, 32'd0);
    end
    wait_idle("idle_timeout");
  endtask

  initial begin
    int cnt;
    int pulses;
    reset = 1; redir_ready = 0; cp0_status = 0; cp0_epc = 0;
    idle_inputs();
    #1;
    chk("rst_cm_ready", {31'd0, cm_ready}, 32'd1);
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    started = 1;

    vecs[0]  = mk(0,0,1,32'hBFC0_0100,0,7'b0010000,0,0,0,1,5'h0C,0,0,32'hBFC0_0100,0,32'hBFC0_0380);
    vecs[1]  = mk(0,0,0,32'h8000_1004,1,7'b0000001,0,32'h3,0,1,5'h05,0,1,32'h8000_1000,32'h3,32'h8000_0180);
    vecs[2]  = mk(0,0,0,32'h8000_0404,1,7'b1000000,0,32'hDEAD_0000,0,1,5'h04,0,1,32'h8000_0400,32'h8000_0404,32'h8000_0180);
    vecs[3]  = mk(0,0,1,32'h8000_0500,0,7'b0000010,0,32'h1234_5679,0,1,5'h04,0,1,32'h8000_0500,32'h1234_5679,32'hBFC0_0380);
    vecs[4]  = mk(0,0,0,32'h8000_0600,0,7'b0100000,0,0,0,1,5'h0A,0,0,32'h8000_0600,0,32'h8000_0180);
    vecs[5]  = mk(0,0,0,32'h8000_0610,0,7'b0001000,0,0,0,1,5'h08,0,0,32'h8000_0610,0,32'h8000_0180);
    vecs[6]  = mk(0,0,0,32'h8000_0620,0,7'b0000100,0,0,0,1,BP_CODE,0,0,32'h8000_0620,0,32'h8000_0180);
    vecs[7]  = mk(0,0,1,32'h8000_0630,0,7'b0111000,0,0,0,1,5'h0A,0,0,32'h8000_0630,0,32'hBFC0_0380);
    vecs[8]  = mk(0,0,0,32'h8000_0640,0,7'b0011000,0,0,0,1,5'h0C,0,0,32'h8000_0640,0,32'h8000_0180);
    vecs[9]  = mk(0,0,0,32'h8000_0650,0,7'b0001100,0,0,0,1,SYSBP_CODE,0,0,32'h8000_0650,0,32'h8000_0180);
    vecs[10] = mk(0,0,0,32'h8000_0660,0,7'b0000011,0,32'h0000_0ABC,0,1,5'h04,0,1,32'h8000_0660,32'h0000_0ABC,32'h8000_0180);
    vecs[11] = mk(1,0,0,32'h8000_0700,0,7'b0001000,0,0,0,1,5'h00,0,0,32'h8000_0700,0,32'h8000_0180);
    vecs[12] = mk(1,1,0,32'h8000_0710,0,7'b0000000,0,0,0,0,5'h00,0,0,0,0,0);
    vecs[13] = mk(1,0,0,32'h8000_0804,1,7'b0000000,1,0,32'h8000_2000,1,5'h00,0,0,32'h8000_0800,0,32'h8000_0180);
    vecs[14] = mk(0,0,1,32'h8000_0900,0,7'b0000000,1,0,32'h8000_3000,1,5'h00,1,0,32'h8000_0900,0,32'h8000_3000);
    vecs[15] = mk(0,0,0,32'h8000_0A00,0,7'b1111111,0,32'h0000_0001,0,1,5'h04,0,1,32'h8000_0A00,32'h8000_0A00,32'h8000_0180);

    foreach (vecs[i]) apply(vecs[i]);

    // ERET with fetch stalling for three cycles; commit keeps offering the ERET.
    @(posedge clk); #1;
    cp0_status = 0; cp0_epc = 32'h8000_2000; redir_ready = 0;
    cm_valid = 1; cm_eret = 1; cm_pc = 32'h8000_0B00;
    qe.push_back('{code: 5'h00, bd: 1'b0, eret: 1'b1, chk_bv: 1'b0, epc: 32'h8000_0B00, badv: 32'h0});
    rq.push_back(32'h8000_2000);
    pulses = 0; cnt = 0;
    @(negedge clk);
    if (exc_valid && exc_eret) pulses++;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (exc_valid) pulses++;
      if (redir_valid) cnt++;
      chk("eret_stall_cm_ready", {31'd0, cm_ready}, 32'd0);
    end
    @(posedge clk); #1;
    redir_ready = 1; idle_inputs();
    @(negedge clk);
    if (exc_valid) pulses++;
    if (redir_valid) cnt++;
    chk("eret_pulses", pulses, 32'd1);
    chk("eret_redir_cycles", cnt, 32'd4);
    @(negedge clk);
    chk("eret_done_ready", {31'd0, cm_ready}, 32'd1);
    chk("eret_done_redir", {31'd0, redir_valid}, 32'd0);

    // Reset while a redirect is outstanding drops it immediately.
    @(posedge clk); #1;
    redir_ready = 0; cm_valid = 1; cm_exc = 7'b0001000; cm_pc = 32'h8000_0C00;
    qe.push_back('{code: 5'h08, bd: 1'b0, eret: 1'b0, chk_bv: 1'b0, epc: 32'h8000_0C00, badv: 32'h0});
    rq.push_back(32'h8000_0180);
    @(posedge clk); #1;
    idle_inputs();
    chk("pre_rst_redir", {31'd0, redir_valid}, 32'd1);
    #1 reset = 1;
    #1;
    chk("midrst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_cm_ready", {31'd0, cm_ready}, 32'd1);
    chk("midrst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("midrst_redir_pc", redir_pc, 32'd0);
    rq.delete();
    @(negedge clk);
    reset = 0; redir_ready = 1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (redir_valid || exc_valid) cnt++;
    end
    chk("no_redir_after_rst", cnt, 32'd0);

    chk("exc_queue_empty", qe.size(), 32'd0);
    chk("redir_queue_empty", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
